luma_fusion_align: RTL and testbench
====================================

Name: luma_fusion_align

Overview:
- Parametrised successor of the Retinex+HE pipeline's fusion stage.
- Re-aligns two independently-latent enhanced luma branches (A = Retinex, B = HE) with the original Y/Cb/Cr and frame markers using internal FIFOs.
- Fuses A and B with a programmable weight, or selects a single source.
- Feeds the YCbCr-to-RGB stage. Branch latencies need not be fixed or equal.

Parameters:
- DATA_W, 8, bits per component (Y/Cb/Cr/A/B).
- WEIGHT_W, 4, fusion weight width; weight scale = 2^WEIGHT_W.
- FIFO_DEPTH, 16, entries per FIFO (power of 2, >= 4); must exceed max branch latency.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  source pixel strobe (Y/Cb/Cr/markers)
- in_sof  in  1  first pixel of frame (qualified by in_valid)
- in_eof  in  1  last pixel of frame (qualified by in_valid)
- in_y  in  DATA_W  original luma
- in_cb  in  DATA_W  chroma Cb
- in_cr  in  DATA_W  chroma Cr
- a_valid  in  1  branch A result strobe
- a_y  in  DATA_W  branch A luma
- b_valid  in  1  branch B result strobe
- b_y  in  DATA_W  branch B luma
- cfg_weight  in  WEIGHT_W  weight of A; B weight = 2^WEIGHT_W - cfg_weight
- cfg_mode  in  2  0 fuse, 1 A only, 2 B only, 3 bypass original Y
- err_clr  in  1  clears sticky error flags
- out_valid  out  1  output pixel strobe
- out_sof  out  1  aligned frame start
- out_eof  out  1  aligned frame end
- out_y  out  DATA_W  fused luma
- out_cb  out  DATA_W  delayed Cb
- out_cr  out  DATA_W  delayed Cr
- err_overflow  out  1  sticky: push into a full FIFO
- err_order  out  1  sticky: branch FIFO non-empty past FIFO_DEPTH cycles while S-FIFO empty
- stat_valid  out  1  one-cycle stats strobe (optional feature)
- stat_min  out  DATA_W  frame min out_y (optional feature)
- stat_max  out  DATA_W  frame max out_y (optional feature)

Behaviour:
- Reset: all outputs 0, FIFOs empty, latched weight/mode 0.
- FIFOs:
  - S-FIFO stores {sof, eof, y, cb, cr}; pushed on in_valid.
  - A-FIFO pushed on a_valid; B-FIFO pushed on b_valid.
  - All first-word-fall-through.
- Overflow: a push to a full FIFO drops the sample and sets err_overflow. Other FIFOs are unaffected.
- Pop: in cycle t, all three FIFOs are popped together iff all three are non-empty. No pop otherwise. There is no downstream backpressure.
- Pipeline, two registered stages:
  - Stage 1 (t+1): products pA = A*w and pB = B*(2^WEIGHT_W - w), plus sideband.
  - Stage 2 (t+2): out_y = (pA + pB + 2^(WEIGHT_W-1)) >> WEIGHT_W. out_valid = 1 at t+2.
- Arithmetic: product width is DATA_W+WEIGHT_W+1; the result cannot exceed 2^DATA_W - 1. cfg_weight = 0 gives pure B.
- Weight/mode latching: sampled only at the pop of an S-FIFO entry with sof = 1, and held for the whole frame. Changes mid-frame take effect at the next sof.
- Mode selection: modes 1/2/3 select A, B or original Y at stage 2. Latency is identical (2 cycles) in every mode.
- Chroma and markers are delayed identically to luma and pass through unmodified.
- Simultaneous push and pop on a full FIFO is legal: no overflow, count unchanged.
- err_order: a counter tracks cycles in which the S-FIFO is empty while A- or B-FIFO is non-empty. The flag sets when the counter reaches FIFO_DEPTH; the counter clears when the condition ends.
- Error clearing: err_clr clears both flags next cycle. A set condition in the same cycle wins over the clear.
- Reset mid-frame: all in-flight data is discarded. The first output after reset must come from entries pushed after reset.

Optional Feature:
- Macro: FUSION_STATS_EN.
- Defined:
  - Tracks min and max of out_y from out_sof through out_eof inclusive.
  - In the cycle after out_valid && out_eof: stat_min/stat_max update and stat_valid pulses for 1 cycle.
  - Trackers reinitialise on each out_sof pixel (min = max = that pixel).
- Undefined: stat_valid, stat_min and stat_max are tied 0; no tracking logic.

Test Plan:
- Equal latency, mode 0, w = 8 (DATA_W = 8, WEIGHT_W = 4): A = 200, B = 100 on the same cycle as in_valid -> out_y = 150 two cycles later, with cb/cr/sof unchanged.
- Skew: A arrives 3 cycles after S, B 9 cycles after S, 5-pixel burst -> 5 outputs in order, each 2 cycles after its B arrival, no errors.
- Rounding: w = 1, A = 255, B = 0 -> out_y = 16 ((255 + 8) >> 4). w = 0 -> out_y = B exactly.
- Weight change mid-frame: w 8 -> 15 after pixel 2 of a frame -> the remainder of that frame uses 8; the next frame's sof pixel onward uses 15.
- Overflow: hold a_valid/b_valid low and push 17 in_valid into depth 16 -> err_overflow = 1, 16 entries retained. Pulsing err_clr -> 0.
- Reset mid-frame with 5 entries queued -> outputs 0 immediately; after release, a new 1-pixel frame with A = B = Y = 42 -> out_y = 42 at t+2, and (if FUSION_STATS_EN) stat_min = stat_max = 42 with stat_valid pulsed.

Source files
------------

// File: rtl/luma_fusion_align.sv
// luma_fusion_align: re-aligns the Retinex (A) and HE (B) luma branches with the source
// pixel stream, then fuses or selects luma. Optional per-frame min/max: FUSION_STATS_EN.
module luma_fusion_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          full, do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push in the cycle it is popped.
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && !do_push;
  assign rdata   = mem_q[rd_q];

  // NOTE: storage is not reset; only pointers and count are, so stale words are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module luma_fusion_align #(
  parameter int DATA_W     = 8,
  parameter int WEIGHT_W   = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic                in_eof,
  input  logic [DATA_W-1:0]   in_y,
  input  logic [DATA_W-1:0]   in_cb,
  input  logic [DATA_W-1:0]   in_cr,
  input  logic                a_valid,
  input  logic [DATA_W-1:0]   a_y,
  input  logic                b_valid,
  input  logic [DATA_W-1:0]   b_y,
  input  logic [WEIGHT_W-1:0] cfg_weight,
  input  logic [1:0]          cfg_mode,
  input  logic                err_clr,
  output logic                out_valid,
  output logic                out_sof,
  output logic                out_eof,
  output logic [DATA_W-1:0]   out_y,
  output logic [DATA_W-1:0]   out_cb,
  output logic [DATA_W-1:0]   out_cr,
  output logic                err_overflow,
  output logic                err_order,
  output logic                stat_valid,
  output logic [DATA_W-1:0]   stat_min,
  output logic [DATA_W-1:0]   stat_max
);
  localparam int PW  = DATA_W + WEIGHT_W + 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {MODE_FUSE, MODE_A, MODE_B, MODE_Y} mode_e;
  typedef struct packed {
    logic              sof;
    logic              eof;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] cb;
    logic [DATA_W-1:0] cr;
  } pix_t;

  pix_t              s_head;
  logic [DATA_W-1:0] a_head, b_head;
  logic              s_empty, a_empty, b_empty, s_ovf, a_ovf, b_ovf, pop;

  luma_fusion_fifo #(.W($bits(pix_t)), .DEPTH(FIFO_DEPTH)) u_s_fifo (
    .clk(clk), .rst(rst), .push(in_valid), .pop(pop),
    .wdata({in_sof, in_eof, in_y, in_cb, in_cr}),
    .rdata(s_head), .empty(s_empty), .ovf(s_ovf));
  luma_fusion_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_a_fifo (
    .clk(clk), .rst(rst), .push(a_valid), .pop(pop), .wdata(a_y),
    .rdata(a_head), .empty(a_empty), .ovf(a_ovf));
  luma_fusion_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_b_fifo (
    .clk(clk), .rst(rst), .push(b_valid), .pop(pop), .wdata(b_y),
    .rdata(b_head), .empty(b_empty), .ovf(b_ovf));

  assign pop = !s_empty && !a_empty && !b_empty;

  // The sof pixel already uses the freshly sampled weight/mode; the rest of the frame holds them.
  logic                sof_pop;
  logic [WEIGHT_W-1:0] w_q, eff_w;
  mode_e               mode_q, eff_mode;
  logic [WEIGHT_W:0]   wa, wb;
  logic [PW-1:0]       pa_d, pb_d;

  assign sof_pop  = pop && s_head.sof;
  assign eff_w    = sof_pop ? cfg_weight : w_q;
  assign eff_mode = sof_pop ? mode_e'(cfg_mode) : mode_q;
  assign wa       = {1'b0, eff_w};
  assign wb       = (WEIGHT_W+1)'(2**WEIGHT_W) - wa;
  assign pa_d     = PW'(a_head) * PW'(wa);
  assign pb_d     = PW'(b_head) * PW'(wb);

  logic              v1_q;
  pix_t              pix1_q;
  logic [DATA_W-1:0] a1_q, b1_q;
  logic [PW-1:0]     pa1_q, pb1_q;
  mode_e             mode1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q     <= '0;
      mode_q  <= MODE_FUSE;
      v1_q    <= 1'b0;
      pix1_q  <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      pa1_q   <= '0;
      pb1_q   <= '0;
      mode1_q <= MODE_FUSE;
    end else begin
      v1_q <= pop;
      if (sof_pop) begin
        w_q    <= cfg_weight;
        mode_q <= mode_e'(cfg_mode);
      end
      if (pop) begin
        pix1_q  <= s_head;
        a1_q    <= a_head;
        b1_q    <= b_head;
        pa1_q   <= pa_d;
        pb1_q   <= pb_d;
        mode1_q <= eff_mode;
      end
    end
  end

  // Weighted sum never exceeds (2^DATA_W-1) * 2^WEIGHT_W + rounding, so PW bits suffice.
  logic [PW-1:0]     sum;
  logic [DATA_W-1:0] y_sel;

  assign sum = pa1_q + pb1_q + PW'(2**(WEIGHT_W-1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    y_sel = sum[WEIGHT_W +: DATA_W];
    case (mode1_q)
      MODE_A:  y_sel = a1_q;
      MODE_B:  y_sel = b1_q;
      MODE_Y:  y_sel = pix1_q.y;
      default: y_sel = sum[WEIGHT_W +: DATA_W];
    endcase
  end

  logic              out_valid_q, out_sof_q, out_eof_q;
  logic [DATA_W-1:0] out_y_q, out_cb_q, out_cr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_y_q     <= '0;
      out_cb_q    <= '0;
      out_cr_q    <= '0;
    end else begin
      out_valid_q <= v1_q;
      out_sof_q   <= v1_q && pix1_q.sof;
      out_eof_q   <= v1_q && pix1_q.eof;
      if (v1_q) begin
        out_y_q  <= y_sel;
        out_cb_q <= pix1_q.cb;
        out_cr_q <= pix1_q.cr;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign out_y     = out_y_q;
  assign out_cb    = out_cb_q;
  assign out_cr    = out_cr_q;

  // Branch data with no matching source pixel for too long means the streams are misordered.
  logic          order_cond, order_set, err_ovf_d, err_ord_d;
  logic [CW-1:0] ord_cnt_q, ord_cnt_d;
  logic          err_ovf_q, err_ord_q;

  assign order_cond = s_empty && (!a_empty || !b_empty);
  assign order_set  = order_cond && (ord_cnt_q == CW'(FIFO_DEPTH));
  assign ord_cnt_d  = !order_cond ? '0 :
                      (ord_cnt_q == CW'(FIFO_DEPTH)) ? ord_cnt_q : ord_cnt_q + 1'b1;
  assign err_ovf_d  = s_ovf || a_ovf || b_ovf || (err_ovf_q && !err_clr);
  assign err_ord_d  = order_set || (err_ord_q && !err_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ord_cnt_q <= '0;
      err_ovf_q <= 1'b0;
      err_ord_q <= 1'b0;
    end else begin
      ord_cnt_q <= ord_cnt_d;
      err_ovf_q <= err_ovf_d;
      err_ord_q <= err_ord_d;
    end
  end

  assign err_overflow = err_ovf_q;
  assign err_order    = err_ord_q;

`ifdef FUSION_STATS_EN
  logic [DATA_W-1:0] run_min_q, run_max_q, run_min_d, run_max_d, st_min_q, st_max_q;
  logic              st_v_q;

  always_comb begin
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    if (out_valid_q) begin
      if (out_sof_q) begin
        run_min_d = out_y_q;
        run_max_d = out_y_q;
      end else begin
        if (out_y_q < run_min_q) run_min_d = out_y_q;
        if (out_y_q > run_max_q) run_max_d = out_y_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_min_q <= '0;
      run_max_q <= '0;
      st_min_q  <= '0;
      st_max_q  <= '0;
      st_v_q    <= 1'b0;
    end else begin
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      st_v_q    <= out_valid_q && out_eof_q;
      if (out_valid_q && out_eof_q) begin
        st_min_q <= run_min_d;
        st_max_q <= run_max_d;
      end
    end
  end

  assign stat_valid = st_v_q;
  assign stat_min   = st_min_q;
  assign stat_max   = st_max_q;
`else
  assign stat_valid = 1'b0;
  assign stat_min   = '0;
  assign stat_max   = '0;
`endif
endmodule

// File: tb/tb_luma_fusion_align.sv
// Self-checking bench for luma_fusion_align: directed vector table plus multi-cycle sequences.
module tb_luma_fusion_align;
  localparam int DATA_W = 8, WEIGHT_W = 4, FIFO_DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_sof, in_eof, a_valid, b_valid, err_clr;
  logic [7:0] in_y, in_cb, in_cr, a_y, b_y;
  logic [3:0] cfg_weight;
  logic [1:0] cfg_mode;
  logic out_valid, out_sof, out_eof, err_overflow, err_order, stat_valid;
  logic [7:0] out_y, out_cb, out_cr, stat_min, stat_max;

  luma_fusion_align #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .a_valid(a_valid), .a_y(a_y),
    .b_valid(b_valid), .b_y(b_y), .cfg_weight(cfg_weight), .cfg_mode(cfg_mode),
    .err_clr(err_clr), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr), .err_overflow(err_overflow),
    .err_order(err_order), .stat_valid(stat_valid), .stat_min(stat_min), .stat_max(stat_max));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [7:0] y, cb, cr;
    logic       sof, eof;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [7:0] a, b, y, cb, cr;
    logic [3:0] w;
    logic [1:0] mode;
    logic [7:0] exp_y;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_px(input logic [7:0] y, cb, cr, input logic sof, eof, input int at);
    exp_t e;
    e.y = y; e.cb = cb; e.cr = cr; e.sof = sof; e.eof = eof; e.at = at;
    exp_q.push_back(e);
  endtask

  // Outputs are sampled 1 time unit after the rising edge; the stream monitor runs here too.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mon_en && out_valid) begin
      if (exp_q.size() == 0) check("unexpected_out", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_y", out_y, e.y);
        check("mon_cb", out_cb, e.cb);
        check("mon_cr", out_cr, e.cr);
        check("mon_sof", out_sof, e.sof);
        check("mon_eof", out_eof, e.eof);
        if (e.at >= 0) check("mon_cycle", cyc, e.at);
      end
    end
  endtask

  task automatic idle();
    in_valid = 0; in_sof = 0; in_eof = 0; a_valid = 0; b_valid = 0; err_clr = 0;
  endtask

  task automatic drive_all(input logic sof, eof, input logic [7:0] y, cb, cr, a, b);
    in_valid = 1; in_sof = sof; in_eof = eof; in_y = y; in_cb = cb; in_cr = cr;
    a_valid = 1; a_y = a; b_valid = 1; b_y = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [7:0] skew_exp [5];
    vecs[0] = '{200, 100, 60, 11, 22, 8, 0, 150};
    vecs[1] = '{255,   0,  1,  2,  3, 1, 0,  16};
    vecs[2] = '{ 37,  99,  4,  5,  6, 0, 0,  99};
    vecs[3] = '{255, 255,  7,  8,  9, 15, 0, 255};
    vecs[4] = '{ 10,  20, 12, 13, 14, 4, 0,  18};
    vecs[5] = '{ 77,  33,  5, 15, 16, 8, 1,  77};
    vecs[6] = '{ 77,  33,  5, 17, 18, 8, 2,  33};
    vecs[7] = '{ 77,  33,  5, 19, 20, 8, 3,   5};
    vecs[8] = '{  0,   0, 90, 21, 22, 8, 0,   0};
    vecs[9] = '{  3,   4, 91, 23, 24, 8, 0,   4};
    skew_exp = '{50, 65, 80, 95, 110};

    rst = 1; idle(); in_y = 0; in_cb = 0; in_cr = 0; a_y = 0; b_y = 0;
    cfg_weight = 0; cfg_mode = 0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_err_order", err_order, 0);
    check("rst_stat_valid", stat_valid, 0);
    rst = 0;
    tick();

    // Branch A data with no source pixels: order error after FIFO_DEPTH cycles, set beats clear.
    a_valid = 1; a_y = 1;
    repeat (3) tick();
    a_valid = 0;
    repeat (7) tick();
    check("order_early", err_order, 0);
    repeat (15) tick();
    check("order_set", err_order, 1);
    check("order_no_ovf", err_overflow, 0);
    err_clr = 1; tick(); err_clr = 0; tick();
    check("order_set_wins_clr", err_order, 1);
    rst = 1; tick(); rst = 0; tick();
    check("order_reset", err_order, 0);

    for (int i = 0; i < 10; i++) begin
      cfg_weight = vecs[i].w; cfg_mode = vecs[i].mode;
      drive_all(1, 1, vecs[i].y, vecs[i].cb, vecs[i].cr, vecs[i].a, vecs[i].b);
      tick();
      idle();
      tick();
      check($sformatf("vec%0d_not_early", i), out_valid, 0);
      tick();
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_y", i), out_y, vecs[i].exp_y);
      check($sformatf("vec%0d_cb", i), out_cb, vecs[i].cb);
      check($sformatf("vec%0d_cr", i), out_cr, vecs[i].cr);
      check($sformatf("vec%0d_sof", i), out_sof, 1);
      check($sformatf("vec%0d_eof", i), out_eof, 1);
      tick();
      check($sformatf("vec%0d_single", i), out_valid, 0);
    end

    // Skew: S at 0..4, A at 3..7, B at 9..13; each output lands 2 cycles after its B push.
    cfg_weight = 8; cfg_mode = 0; mon_en = 1; c0 = cyc;
    for (int i = 0; i < 5; i++)
      expect_px(skew_exp[i], 8'(50 + i), 8'(60 + i), i == 0, i == 4, c0 + 12 + i);
    for (int k = 0; k < 20; k++) begin
      idle();
      if (k < 5) begin
        in_valid = 1; in_sof = (k == 0); in_eof = (k == 4);
        in_y = 8'(k + 1); in_cb = 8'(50 + k); in_cr = 8'(60 + k);
      end
      if (k >= 3 && k < 8) begin a_valid = 1; a_y = 8'(100 + 10 * (k - 3)); end
      if (k >= 9 && k < 14) begin b_valid = 1; b_y = 8'(20 * (k - 9)); end
      tick();
    end
    idle();
    check("skew_all_out", exp_q.size(), 0);
    check("skew_no_ovf", err_overflow, 0);
    check("skew_no_order", err_order, 0);

    // Weight 8 -> 15 from pixel 2: frame 1 keeps 8, next frame's sof picks up 15.
    c0 = cyc;
    for (int k = 0; k < 6; k++)
      expect_px(k < 4 ? 8'd80 : 8'd150, 8'(k), 8'(k + 30), k == 0 || k == 4,
                k == 3 || k == 5, c0 + k + 3);
    for (int k = 0; k < 6; k++) begin
      cfg_weight = (k < 2) ? 4'd8 : 4'd15;
      drive_all(k == 0 || k == 4, k == 3 || k == 5, 8'(k + 70), 8'(k), 8'(k + 30), 160, 0);
      tick();
    end
    idle();
    repeat (4) tick();
    check("wchg_all_out", exp_q.size(), 0);

    // Overflow: 17 source pushes into 16 entries, then drain with one legal push-on-full.
    cfg_mode = 3; cfg_weight = 0;
    for (int i = 0; i < 16; i++) expect_px(8'(i), 8'(i), 8'(i + 100), i == 0, 0, -1);
    expect_px(99, 9, 9, 0, 1, -1);
    for (int i = 0; i < 17; i++) begin
      idle();
      in_valid = 1; in_sof = (i == 0); in_y = 8'(i); in_cb = 8'(i); in_cr = 8'(i + 100);
      tick();
    end
    idle();
    tick();
    check("ovf_set", err_overflow, 1);
    check("ovf_no_order", err_order, 0);
    check("ovf_no_out", out_valid, 0);
    err_clr = 1; tick(); err_clr = 0; tick();
    check("ovf_cleared", err_overflow, 0);
    for (int k = 0; k < 17; k++) begin
      idle();
      a_valid = 1; a_y = 8'(k); b_valid = 1; b_y = 8'(k);
      if (k == 1) begin
        in_valid = 1; in_eof = 1; in_y = 99; in_cb = 9; in_cr = 9;
      end
      tick();
    end
    idle();
    repeat (5) tick();
    check("ovf_drain_all", exp_q.size(), 0);
    check("ovf_push_on_full_ok", err_overflow, 0);
    mon_en = 0;

    // Reset mid-frame with five source entries queued.
    for (int i = 0; i < 5; i++) begin
      idle();
      in_valid = 1; in_sof = (i == 0); in_y = 8'(i + 1); in_cb = 3; in_cr = 4;
      tick();
    end
    idle();
    check("pre_rst_y_held", out_y, 99);
    #2 rst = 1;
    #1;
    check("mid_rst_y", out_y, 0);
    check("mid_rst_cb", out_cb, 0);
    check("mid_rst_valid", out_valid, 0);
    tick(); tick();
    rst = 0;
    tick();
    cfg_mode = 0; cfg_weight = 8;
    drive_all(1, 1, 42, 7, 9, 42, 42);
    tick();
    idle();
    tick();
    check("post_rst_not_early", out_valid, 0);
    tick();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_y", out_y, 42);
    check("post_rst_cb", out_cb, 7);
    check("post_rst_cr", out_cr, 9);
    tick();
    check("post_rst_single", out_valid, 0);
`ifdef FUSION_STATS_EN
    check("stat_valid_pulse", stat_valid, 1);
    check("stat_min", stat_min, 42);
    check("stat_max", stat_max, 42);
    tick();
    check("stat_valid_one_cycle", stat_valid, 0);
`else
    check("stat_valid_tied", stat_valid, 0);
    check("stat_min_tied", stat_min, 0);
    check("stat_max_tied", stat_max, 0);
`endif
    check("final_no_ovf", err_overflow, 0);
    check("final_no_order", err_order, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
